// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller: double-buffered multiplexed seven-segment scan controller.
// Define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits of each committed frame.
module sseg_scan_controller #(
  parameter int DIGITS      = 8,
  parameter int BITS        = 3,
  parameter int REFRESH_DIV = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  output logic [3:0]          num,
  output logic [BITS-1:0]     active_digit,
  output logic                DP_ctrl,
  output logic                en,
  output logic                pending,
  output logic                frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0]       r_cnt;
  logic [BITS-1:0]     r_idx;
  logic [3:0]          r_num;
  logic                r_dp;
  logic                r_en;
  logic                r_pending;
  logic                r_frame_done;
  logic                r_valid;
  logic [4*DIGITS-1:0] r_disp_dig;
  logic [4*DIGITS-1:0] r_pend_dig;
  logic [DIGITS-1:0]   r_disp_dp;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                w_tick;
  logic                w_wrap;
  logic                w_commit;
  logic [BITS-1:0]     w_next;
  logic [4*DIGITS-1:0] w_src_dig;
  logic [DIGITS-1:0]   w_src_dp;
  logic [DIGITS-1:0]   w_src_blank;
  logic [3:0]          w_num;
  logic                w_dp;
  logic                w_blank;
  assign w_tick    = r_cnt == CW'(REFRESH_DIV - 1);
  assign w_wrap    = w_tick && r_idx == BITS'(DIGITS - 1);
  assign w_commit  = w_wrap && r_pending;
  assign w_next    = w_wrap ? '0 : r_idx + BITS'(1);
  // On a commit edge the new frame is already the source for digit 0.
  assign w_src_dig = w_commit ? r_pend_dig : r_disp_dig;
  assign w_src_dp  = w_commit ? r_pend_dp : r_disp_dp;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_new_blank;
  logic              w_run;
  // A digit blanks only while every digit above it is also a blanked zero.
  always_comb begin
    w_new_blank = '0;
    w_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      w_run = w_run && r_pend_dig[4*i +: 4] == 4'd0 && !r_pend_dp[i];
      w_new_blank[i] = w_run;
    end
  end
  assign w_src_blank = w_commit ? w_new_blank : r_blank;
`else
  assign w_src_blank = '0;
`endif
  always_comb begin
    w_num = '0;
    w_dp = 1'b0;
    w_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (w_next == BITS'(i)) begin
        w_num = w_src_dig[4*i +: 4];
        w_dp = w_src_dp[i];
        w_blank = w_src_blank[i];
      end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_num        <= '0;
      r_dp         <= 1'b0;
      r_en         <= 1'b0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_valid      <= 1'b0;
      r_disp_dig   <= '0;
      r_pend_dig   <= '0;
      r_disp_dp    <= '0;
      r_pend_dp    <= '0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      r_blank      <= '0;
`endif
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + CW'(1);
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_idx <= w_next;
        r_num <= w_num;
        r_dp  <= w_dp;
        r_en  <= (w_commit || r_valid) && !w_blank;
      end
      if (w_commit) begin
        r_disp_dig <= r_pend_dig;
        r_disp_dp  <= r_pend_dp;
        r_valid    <= 1'b1;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        r_blank    <= w_new_blank;
`endif
      end
      if (load) begin
        r_pend_dig <= digits_in;
        r_pend_dp  <= dp_in;
        r_pending  <= 1'b1;
      end else if (w_commit) begin
        r_pending  <= 1'b0;
      end
    end
  end
  assign num          = r_num;
  assign active_digit = r_idx;
  assign DP_ctrl      = r_dp;
  assign en           = r_en;
  assign pending      = r_pending;
  assign frame_done   = r_frame_done;
endmodule

// File: doc/sseg_scan_controller.md
Name: sseg_scan_controller

Overview:
- Multiplexed-display scan controller. It is the producer side of the seven-segment driver interface: it generates the num / active_digit / DP_ctrl / en bundle that first_sseg_driver consumes.
- Holds a full frame of BCD digits and rotates active_digit at a divided refresh rate.
- New frames from the stopwatch datapath are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- DIGITS, 8, number of multiplexed digits (2..8).
- BITS, 3, width of active_digit; must satisfy 2^BITS >= DIGITS.
- REFRESH_DIV, 500000, clk cycles per digit slot (>= 2).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- digits_in  input  4*DIGITS  BCD frame; digit i at bits [4i+3:4i]
- dp_in  input  DIGITS  decimal-point request per digit
- load  input  1  single-cycle strobe; captures digits_in/dp_in into the pending buffer
- num  output  4  BCD value of the currently active digit
- active_digit  output  BITS  index of the digit being driven
- DP_ctrl  output  1  decimal point for the active digit
- en  output  1  digit enable (0 = blank)
- pending  output  1  a captured frame is waiting for commit
- frame_done  output  1  one-cycle pulse on frame commit/wrap

Behaviour:
- Reset (async, reset_n=0) sets every register to zero: prescaler 0, active_digit 0, num 0, DP_ctrl 0, en 0, pending 0, frame_done 0, display and pending buffers 0, display_valid 0. Reset applied mid-frame or mid-load aborts immediately; no partial commit.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - tick is an internal signal, high in the cycle where the count equals REFRESH_DIV-1.
  - The count returns to 0 on the following edge.
- Scan:
  - On the clock edge where tick is high, active_digit increments.
  - At DIGITS-1 it wraps to 0 (e.g. DIGITS=6: 5 -> 0; values 6,7 are never produced).
- Outputs num, DP_ctrl and en are registered. They update on the same edge as active_digit and are taken from the display buffer at the new index, so there is zero cycles of skew between index and data.
- Load:
  - load=1 captures digits_in/dp_in into the pending buffer and sets pending=1 on the next edge.
  - A later load before commit overwrites the pending buffer (last write wins).
- Commit:
  - Occurs on a tick edge where active_digit == DIGITS-1 and pending == 1.
  - On that edge, the pending buffer is copied to the display buffer, pending clears, and display_valid sets.
  - Digit 0 data output on that same edge already comes from the new frame.
- Simultaneous load and commit: the commit uses the old pending contents; the new capture is written to the pending buffer and pending stays 1.
- frame_done goes high for one cycle, registered, after every wrap edge (active_digit DIGITS-1 -> 0), whether or not a commit occurred.
- en = display_valid. Before the first commit, the display is blank (en=0) even though scanning runs.
- BCD values 10..15 pass through unmodified; decoding them is the driver's concern.

Optional Feature:
- Macro: SSEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - en for digit i is forced to 0 when display_valid=1, digit i == 0, dp_in bit i == 0 in the committed frame, and every higher-index digit is also a blanked zero.
  - Digit 0 is never blanked.
  - The blank mask is computed at commit time and stored with the display buffer; it adds no extra latency.
- Undefined: en = display_valid for all digits.

Test Plan:
- Reset / blank: assert reset_n=0 mid-count, release -> all outputs 0; with REFRESH_DIV=4, DIGITS=8, active_digit steps 0,1,..,7,0 every 4 cycles; en=0 throughout with no load.
- Single frame commit: load with digits_in=0x87654321, dp_in=8'h04 while active_digit=3 -> pending=1. Display stays blank until the 7->0 edge, then en=1, num=1 at digit 0, num=3 with DP_ctrl=1 at digit 2; frame_done pulses once per wrap.
- Overwrite before commit: load 0x11111111 then 0x22222222 within one frame -> only 2s ever displayed.
- Load coincident with commit edge: load 0x33333333 exactly on the wrap tick while 0x22222222 is pending -> the next frame shows 2s, pending stays 1, and the following frame shows 3s.
- DIGITS=6, BITS=3 -> active_digit never exceeds 5; frame_done every 6*REFRESH_DIV cycles.
- With SSEG_LEADING_ZERO_BLANK_EN, commit 0x00000105, dp_in=0 -> en=1 for digits 0..2, en=0 for digits 3..7. Commit 0x00000000 -> only digit 0 is enabled. Without the macro, all 8 digits are enabled.
